// File: rtl/bounce_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : bounce_counter_param
// Description : Parametrised up/down sequence counter with programmable
//               bounds and step. Supports up-wrap, down-wrap and bounce
//               (ping-pong) modes, with an optional dwell at each bounce
//               turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_counter_param #(
  parameter int W     = 10,
  parameter int DWELL = 0,
  parameter int DW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [W-1:0] step,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] out,
  output logic         dir,
  output logic         turn,
  output logic         cfg_err
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  localparam logic [1:0]    MODE_UP     = 2'b00;
  localparam logic [1:0]    MODE_DOWN   = 2'b01;
  localparam logic [1:0]    MODE_BOUNCE = 2'b10;
  localparam logic [1:0]    MODE_HOLD   = 2'b11;
  localparam bit            HAS_DWELL   = (DWELL > 0);
  localparam logic [DW-1:0] DWELL_LAST  = DW'((DWELL > 0) ? DWELL - 1 : 0);

  state_t        state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  out_nxt;
  logic          dir_nxt;
  logic          turn_nxt;

  logic [W-1:0]  step_eff;
  logic [W-1:0]  load_clamped;
  logic [W:0]    up_sum;
  logic [W:0]    lo_plus_s;
  logic          up_over;
  logic          up_reach;
  logic          dn_under;
  logic          dn_reach;
  logic          below_lo;
  logic          above_hi;

  assign cfg_err = (lo > hi);

  // A zero step would stall the counter, so it behaves as a step of one.
  assign step_eff = (step == '0) ? W'(1) : step;

  // Bound arithmetic is one bit wider so out+step never wraps silently.
  assign up_sum    = {1'b0, out} + {1'b0, step_eff};
  assign lo_plus_s = {1'b0, lo}  + {1'b0, step_eff};

  // Wrap modes hit the bound only when the step would overshoot it.
  assign up_over  = (up_sum > {1'b0, hi});
  assign dn_under = ({1'b0, out} < lo_plus_s);

  // Bounce treats landing exactly on a bound as the turnaround, so the
  // bound value is shown once rather than twice in the ping-pong sequence.
  assign up_reach = (up_sum >= {1'b0, hi});
  assign dn_reach = ({1'b0, out} <= lo_plus_s);

  assign below_lo = (out < lo);
  assign above_hi = (out > hi);

  assign load_clamped = (load_val < lo) ? lo :
                        (load_val > hi) ? hi : load_val;

  // Next-state / next-output decode: cfg_err > load > !en > mode.
  always_comb begin
    out_nxt   = out;
    dir_nxt   = dir;
    turn_nxt  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!cfg_err) begin
      if (load) begin
        out_nxt   = load_clamped;
        dir_nxt   = (mode != MODE_DOWN);
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end else if (en && (mode != MODE_HOLD)) begin
        if (below_lo || above_hi) begin
          // Bounds moved under the counter: pull it back in, take no step.
          out_nxt   = below_lo ? lo : hi;
          turn_nxt  = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          if (mode == MODE_UP) begin
            dir_nxt = 1'b1;
          end else if (mode == MODE_DOWN) begin
            dir_nxt = 1'b0;
          end
        end else begin
          case (mode)
            MODE_UP: begin
              dir_nxt   = 1'b1;
              state_nxt = ST_RUN;
              cnt_nxt   = '0;
              if (up_over) begin
                out_nxt  = lo;
                turn_nxt = 1'b1;
              end else begin
                out_nxt = up_sum[W-1:0];
              end
            end
            MODE_DOWN: begin
              dir_nxt   = 1'b0;
              state_nxt = ST_RUN;
              cnt_nxt   = '0;
              if (dn_under) begin
                out_nxt  = hi;
                turn_nxt = 1'b1;
              end else begin
                out_nxt = out - step_eff;
              end
            end
            MODE_BOUNCE: begin
              if (state == ST_DWELL) begin
                if (cnt == DWELL_LAST) begin
                  dir_nxt   = ~dir;
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
                end else begin
                  cnt_nxt = cnt + DW'(1);
                end
              end else if (dir) begin
                if (up_reach) begin
                  out_nxt  = hi;
                  turn_nxt = 1'b1;
                  if (HAS_DWELL) begin
                    state_nxt = ST_DWELL;
                    cnt_nxt   = '0;
                  end else begin
                    dir_nxt = 1'b0;
                  end
                end else begin
                  out_nxt = up_sum[W-1:0];
                end
              end else begin
                if (dn_reach) begin
                  out_nxt  = lo;
                  turn_nxt = 1'b1;
                  if (HAS_DWELL) begin
                    state_nxt = ST_DWELL;
                    cnt_nxt   = '0;
                  end else begin
                    dir_nxt = 1'b1;
                  end
                end else begin
                  out_nxt = out - step_eff;
                end
              end
            end
            default: begin
              out_nxt = out;
            end
          endcase
        end
      end
    end
  end

  // State, count and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      dir   <= 1'b1;
      turn  <= 1'b0;
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      out   <= out_nxt;
      dir   <= dir_nxt;
      turn  <= turn_nxt;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire
